// File: rtl/i2s_tx_multichannel.sv
// Multichannel I2S / left-justified / TDM serial audio transmitter with a
// one-frame holding buffer on a valid/ready handshake.
module i2s_tx_multichannel #(
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 16,
  parameter int CLK_DIV     = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            mode,
  input  logic [CHANNELS*SAMPLE_BITS-1:0] sample_in,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  output logic                            i2s_bck,
  output logic                            i2s_lrck,
  output logic                            i2s_data,
  output logic                            frame_start,
  output logic                            underrun
);

  localparam int TOTAL   = CHANNELS * SLOT_BITS;
  localparam int FRAME_W = CHANNELS * SAMPLE_BITS;
  localparam int CNT_W   = $clog2(TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bck_q, bck_d;
  logic               lrck_q, lrck_d;
  logic               data_q, data_d;
  logic               dly_q, dly_d;
  logic               fs_q, fs_d;
  logic               ur_q, ur_d;
  logic               ready_q, ready_d;
  logic               full_q, full_d;
  logic               mode_q, mode_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic                   fall;
  logic                   accept;
  logic                   lj_bit;
  logic [SAMPLE_BITS-1:0] samp;
  int                     slot;
  int                     pos;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q   <= '0;
      cnt_q   <= CNT_LAST;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      data_q  <= 1'b0;
      dly_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      ready_q <= 1'b0;
      full_q  <= 1'b0;
      mode_q  <= 1'b0;
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bck_q   <= bck_d;
      lrck_q  <= lrck_d;
      data_q  <= data_d;
      dly_q   <= dly_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      ready_q <= ready_d;
      full_q  <= full_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    bck_d   = bck_q;
    lrck_d  = lrck_q;
    data_d  = data_q;
    dly_d   = dly_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    full_d  = full_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    fall    = 1'b0;
    lj_bit  = 1'b0;
    samp    = '0;
    slot    = 0;
    pos     = 0;
    accept  = sample_valid && ready_q;

    if (accept) begin
      full_d = 1'b1;
      hold_d = sample_in;
    end

    if (div_q == DIV_LAST) begin
      div_d = '0;
      bck_d = !bck_q;
      fall  = bck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (fall) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        fs_d   = 1'b1;
        mode_d = mode;
        // Decision uses pre-accept buffer state: a same-cycle accept is held for the next frame.
        if (full_q) begin
          frame_d = hold_q;
          full_d  = 1'b0;
        end else begin
          ur_d = 1'b1;
        end
      end
      slot = int'(cnt_d) / SLOT_BITS;
      pos  = int'(cnt_d) % SLOT_BITS;
      for (int c = 0; c < CHANNELS; c++)
        if (slot == c) samp = frame_d[c*SAMPLE_BITS +: SAMPLE_BITS];
      for (int b = 0; b < SAMPLE_BITS; b++)
        if (pos == b) lj_bit = samp[SAMPLE_BITS-1-b];
      dly_d  = lj_bit;
      data_d = mode_d ? lj_bit : dly_q;
      if (CHANNELS == 2) lrck_d = (slot == 1);
      else               lrck_d = (cnt_d == '0);
    end

    ready_d = !full_d;
  end

  assign sample_ready = ready_q;
  assign i2s_bck      = bck_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_data     = data_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_i2s_tx_multichannel.sv
// Directed bench: stereo I2S, left-justified with wide slots, and 4-channel TDM
// instances sharing one clock and reset.
module tb_i2s_tx_multichannel;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] st_in = '0;
  logic        st_valid = 1'b0;
  logic        st_ready, st_bck, st_lrck, st_data, st_fs, st_ur;
  logic [31:0] lj_in = '0;
  logic        lj_valid = 1'b0;
  logic        lj_ready, lj_bck, lj_lrck, lj_data, lj_fs, lj_ur;
  logic [63:0] tdm_in = '0;
  logic        tdm_valid = 1'b0;
  logic        tdm_ready, tdm_bck, tdm_lrck, tdm_data, tdm_fs, tdm_ur;

  i2s_tx_multichannel #(.CHANNELS(2), .SAMPLE_BITS(16), .SLOT_BITS(16), .CLK_DIV(2)) u_st (
    .clk(clk), .reset_n(reset_n), .mode(1'b0), .sample_in(st_in), .sample_valid(st_valid),
    .sample_ready(st_ready), .i2s_bck(st_bck), .i2s_lrck(st_lrck), .i2s_data(st_data),
    .frame_start(st_fs), .underrun(st_ur));

  i2s_tx_multichannel #(.CHANNELS(2), .SAMPLE_BITS(16), .SLOT_BITS(24), .CLK_DIV(2)) u_lj (
    .clk(clk), .reset_n(reset_n), .mode(1'b1), .sample_in(lj_in), .sample_valid(lj_valid),
    .sample_ready(lj_ready), .i2s_bck(lj_bck), .i2s_lrck(lj_lrck), .i2s_data(lj_data),
    .frame_start(lj_fs), .underrun(lj_ur));

  i2s_tx_multichannel #(.CHANNELS(4), .SAMPLE_BITS(16), .SLOT_BITS(16), .CLK_DIV(2)) u_tdm (
    .clk(clk), .reset_n(reset_n), .mode(1'b1), .sample_in(tdm_in), .sample_valid(tdm_valid),
    .sample_ready(tdm_ready), .i2s_bck(tdm_bck), .i2s_lrck(tdm_lrck), .i2s_data(tdm_data),
    .frame_start(tdm_fs), .underrun(tdm_ur));

  // Stereo-instance monitors: BCK half-period length and underrun pulse count.
  int   hp_err = 0;
  int   hp_run = 0;
  bit   hp_started = 0;
  logic st_bck_p = 1'b0;
  int   st_ur_cnt = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      hp_run = 0; hp_started = 0; st_bck_p = 1'b0;
    end else begin
      if (st_bck !== st_bck_p) begin
        if (hp_started && hp_run != 2) hp_err++;
        hp_started = 1; hp_run = 1;
      end else begin
        hp_run++;
      end
      st_bck_p = st_bck;
      if (st_ur === 1'b1) st_ur_cnt++;
    end
  end

  function automatic logic [4:0] sig(input int w);
    case (w)
      0:       return {st_bck, st_data, st_lrck, st_fs, st_ur};
      1:       return {lj_bck, lj_data, lj_lrck, lj_fs, lj_ur};
      default: return {tdm_bck, tdm_data, tdm_lrck, tdm_fs, tdm_ur};
    endcase
  endfunction

  task automatic wait_fs(input int w, output int c, output bit to);
    logic [4:0] s;
    int g = 0;
    do begin
      @(negedge clk); s = sig(w); g++;
    end while (s[1] !== 1'b1 && g < 2000);
    to = (s[1] !== 1'b1);
    c  = cyc;
  endtask

  // Collects n serial bits MSB-first starting with the bit present now (a frame-start cycle).
  task automatic capture(input int w, input int n, output logic [63:0] d,
                         output logic [63:0] lr, output int hi, output bit to);
    logic [4:0] s;
    int g = 0;
    s = sig(w);
    d = {63'd0, s[3]}; lr = {63'd0, s[2]}; hi = (s[2] === 1'b1) ? 1 : 0;
    for (int k = 1; k < n; k++) begin
      do begin @(negedge clk); s = sig(w); hi += (s[2] === 1'b1) ? 1 : 0; g++; end
        while (s[4] !== 1'b1 && g < 4000);
      do begin @(negedge clk); s = sig(w); hi += (s[2] === 1'b1) ? 1 : 0; g++; end
        while (s[4] !== 1'b0 && g < 4000);
      d = {d[62:0], s[3]}; lr = {lr[62:0], s[2]};
    end
    to = (g >= 4000);
  endtask

  int c0, c1, c3, c5;

  task automatic test_reset();
    int rel;
    reset_n = 1'b0;
    st_valid = 1'b1; lj_valid = 1'b1; tdm_valid = 1'b1;
    st_in  = {16'h0F01, 16'hA5C3};
    lj_in  = {16'h7FFE, 16'h8001};
    tdm_in = {16'hD004, 16'h00C3, 16'h0B02, 16'hA001};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({st_ready, st_bck, st_lrck, st_data, st_fs, st_ur,
           lj_ready, lj_bck, lj_lrck, lj_data, lj_fs, lj_ur,
           tdm_ready, tdm_bck, tdm_lrck, tdm_data, tdm_fs, tdm_ur} !== 18'd0) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: outputs not all 0 (st_ready=%b st_bck=%b)", i, st_ready, st_bck);
      end
    end
    reset_n = 1'b1;
    rel = cyc;
    @(negedge clk);
    n_tests++;
    if ({st_ready, lj_ready, tdm_ready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_reset got %b want 111", {st_ready, lj_ready, tdm_ready});
    end
    n_tests++;
    if (st_bck !== 1'b0) begin n_fail++; $display("FAIL bck_clk1 got %b want 0", st_bck); end
    @(negedge clk);
    n_tests++;
    if ({st_ready, lj_ready, tdm_ready} !== 3'b000) begin
      n_fail++; $display("FAIL ready_after_accept got %b want 000", {st_ready, lj_ready, tdm_ready});
    end
    n_tests++;
    if (st_bck !== 1'b1) begin n_fail++; $display("FAIL bck_first_rise got %b want 1", st_bck); end
    st_valid = 1'b0; lj_valid = 1'b0; tdm_valid = 1'b0;
    st_in = 32'hFFFF_FFFF;
    @(negedge clk);
    n_tests++;
    if ({st_bck, st_fs} !== 2'b10) begin n_fail++; $display("FAIL clk3_bck_fs got %b want 10", {st_bck, st_fs}); end
    @(negedge clk);
    n_tests++;
    if ({st_bck, st_fs, st_ur, st_data, st_lrck, st_ready} !== 6'b010001) begin
      n_fail++; $display("FAIL first_fall bck,fs,ur,data,lrck,ready got %b want 010001",
                         {st_bck, st_fs, st_ur, st_data, st_lrck, st_ready});
    end
    n_tests++;
    if (cyc - rel != 4) begin n_fail++; $display("FAIL first_fall_clk got %0d want 4", cyc - rel); end
    c0 = cyc;
  endtask

  task automatic test_stereo_i2s();
    logic [63:0] d, lr;
    int hi;
    bit to;
    capture(0, 32, d, lr, hi, to);
    n_tests++;
    if (to || d[31:0] !== {1'b0, 16'hA5C3, 15'h0780}) begin
      n_fail++; $display("FAIL stereo_frame1_data got %h want %h (to=%0d)", d[31:0], {1'b0, 16'hA5C3, 15'h0780}, to);
    end
    n_tests++;
    if (lr[31:0] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL stereo_lrck got %h want 0000ffff", lr[31:0]); end
  endtask

  task automatic test_underrun();
    logic [63:0] d, lr;
    int hi, urc;
    bit to;
    urc = st_ur_cnt;
    wait_fs(0, c1, to);
    n_tests++;
    if (to || c1 - c0 != 128) begin n_fail++; $display("FAIL stereo_frame_period got %0d want 128 (to=%0d)", c1 - c0, to); end
    n_tests++;
    if (st_ur !== 1'b1) begin n_fail++; $display("FAIL underrun_pulse got %b want 1", st_ur); end
    capture(0, 32, d, lr, hi, to);
    n_tests++;
    if (to || d[31:0] !== {1'b1, 16'hA5C3, 15'h0780}) begin
      n_fail++; $display("FAIL replay_data got %h want %h", d[31:0], {1'b1, 16'hA5C3, 15'h0780});
    end
    n_tests++;
    if (st_ur_cnt - urc != 1) begin n_fail++; $display("FAIL underrun_width got %0d clk want 1", st_ur_cnt - urc); end
  endtask

  task automatic test_late_valid();
    logic [63:0] d, lr;
    int hi, g;
    bit to;
    g = 0;
    while (cyc < c1 + 127 && g < 500) begin @(negedge clk); g++; end
    st_valid = 1'b1;
    st_in = {16'h8001, 16'h1234};
    @(negedge clk);
    st_valid = 1'b0;
    st_in = 32'h5555_AAAA;
    n_tests++;
    if ({st_fs, st_ur, st_ready} !== 3'b110) begin
      n_fail++; $display("FAIL late_valid fs,ur,ready got %b want 110", {st_fs, st_ur, st_ready});
    end
    capture(0, 32, d, lr, hi, to);
    n_tests++;
    if (to || d[31:0] !== {1'b1, 16'hA5C3, 15'h0780}) begin
      n_fail++; $display("FAIL late_valid_replay got %h want %h", d[31:0], {1'b1, 16'hA5C3, 15'h0780});
    end
    wait_fs(0, c3, to);
    n_tests++;
    if (to || st_ur !== 1'b0) begin n_fail++; $display("FAIL late_frame_underrun got %b want 0 (to=%0d)", st_ur, to); end
    capture(0, 32, d, lr, hi, to);
    n_tests++;
    if (to || d[31:0] !== {1'b1, 16'h1234, 15'h4000}) begin
      n_fail++; $display("FAIL late_frame_data got %h want %h", d[31:0], {1'b1, 16'h1234, 15'h4000});
    end
  endtask

  task automatic test_back_to_back();
    int acc, urc;
    bit to;
    acc = 0; urc = 0;
    wait_fs(0, c5, to);
    n_tests++;
    if (to || st_ur !== 1'b1) begin n_fail++; $display("FAIL b2b_start_underrun got %b want 1", st_ur); end
    st_valid = 1'b1;
    st_in = {16'h5A5A, 16'hC0DE};
    for (int i = 0; i < 384; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) urc = st_ur_cnt;
      if (st_valid && st_ready) acc++;
      if (i == 64) begin
        n_tests++;
        if (st_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_midframe got %b want 0", st_ready); end
      end
    end
    st_valid = 1'b0;
    n_tests++;
    if (acc != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", acc); end
    n_tests++;
    if (st_ur_cnt - urc != 0) begin n_fail++; $display("FAIL b2b_underruns got %0d want 0", st_ur_cnt - urc); end
    n_tests++;
    if (hp_err != 0) begin n_fail++; $display("FAIL bck_half_period errors got %0d want 0", hp_err); end
  endtask

  task automatic test_left_justified();
    logic [63:0] d, lr;
    int hi, c, c2;
    bit to;
    wait_fs(1, c, to);
    capture(1, 48, d, lr, hi, to);
    n_tests++;
    if (to || d[47:0] !== 48'h8001_00_7FFE_00) begin
      n_fail++; $display("FAIL lj_data got %h want 8001007ffe00 (to=%0d)", d[47:0], to);
    end
    n_tests++;
    if (lr[47:0] !== 48'h0000_00FF_FFFF) begin n_fail++; $display("FAIL lj_lrck got %h want 000000ffffff", lr[47:0]); end
    wait_fs(1, c2, to);
    n_tests++;
    if (to || c2 - c != 192) begin n_fail++; $display("FAIL lj_frame_period got %0d want 192", c2 - c); end
  endtask

  task automatic test_tdm();
    logic [63:0] d, lr;
    int hi, c, c2;
    bit to;
    wait_fs(2, c, to);
    capture(2, 64, d, lr, hi, to);
    n_tests++;
    if (to || d !== 64'hA001_0B02_00C3_D004) begin
      n_fail++; $display("FAIL tdm_data got %h want a0010b0200c3d004 (to=%0d)", d, to);
    end
    n_tests++;
    if (lr !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL tdm_fsync_bits got %h want 8000000000000000", lr); end
    n_tests++;
    if (hi != 4) begin n_fail++; $display("FAIL tdm_fsync_clks got %0d want 4", hi); end
    wait_fs(2, c2, to);
    n_tests++;
    if (to || c2 - c != 256) begin n_fail++; $display("FAIL tdm_frame_period got %0d want 256", c2 - c); end
  endtask

  initial begin
    test_reset();
    test_stereo_i2s();
    test_underrun();
    test_late_valid();
    test_back_to_back();
    test_left_justified();
    test_tdm();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx_multichannel.md
# i2s_tx_multichannel

Parametrised serial audio transmitter driving the I2S_BCK / I2S_LRCK / I2S_DATA pins from the core's mixed audio. It generalises the fixed stereo output to N channels, configurable sample and slot widths, and a selectable bit clock divider. It supports I2S (one-bit delay) and left-justified framing; with more than two channels it runs TDM with a one-BCK frame-sync pulse. A one-frame holding buffer with a valid/ready handshake decouples the audio producer, and underruns are flagged.

## Interface
- CHANNELS, 2: channels per frame; 2 = stereo LRCK, >2 = TDM frame sync; must be ≥2.
- SAMPLE_BITS, 16: bits per sample, two's complement, MSB first; must be ≤ SLOT_BITS.
- SLOT_BITS, 16: BCK periods per channel slot; bits after the sample are 0.
- CLK_DIV, 4: clk cycles per BCK half-period; must be ≥1.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  1  0 = I2S (data one BCK after LRCK edge), 1 = left-justified; sampled at frame start only.
- sample_in  in  CHANNELS*SAMPLE_BITS  frame data; channel 0 (left) in the LSB field.
- sample_valid  in  1  producer has a frame on sample_in.
- sample_ready  out  1  holding buffer empty; a frame is accepted on clk when valid && ready.
- i2s_bck  out  1  bit clock, period 2*CLK_DIV clk.
- i2s_lrck  out  1  stereo: 0 = left slot, 1 = right slot; TDM: high for the first BCK period of slot 0.
- i2s_data  out  1  serial data; changes only on BCK falling edges.
- frame_start  out  1  one-clk pulse at the falling edge that starts a frame.
- underrun  out  1  one-clk pulse when a frame starts with the holding buffer empty.

## Operation
- Divider counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and i2s_bck toggles. A 1→0 toggle is a fall event.
- Bit counter spans 0..CHANNELS*SLOT_BITS-1. It advances on each fall event and wraps to 0.
- slot = count / SLOT_BITS; position p = count % SLOT_BITS.
- Frame start is the fall event where the count becomes 0. On that event:
  - If the holding buffer is full, it is copied into the frame shift register and the buffer is marked empty.
  - If the buffer is empty, the previous frame is replayed and underrun pulses.
  - mode is latched at this point.
- Holding buffer: an accept sets it full. sample_ready = !full (registered).
  - The frame-start decision uses the buffer state before any same-cycle accept. No bypass: accept and empty transfer in the same cycle gives underrun, and the accepted frame is held for the next frame.
- Left-justified stream: in slot s at position p, output sample s bit [SAMPLE_BITS-1-p] for p < SAMPLE_BITS, otherwise 0.
- I2S mode: i2s_data is the left-justified stream delayed by one BCK period via a flop updated on fall events.
  - Bit 0 of a frame carries the last bit of the previous frame's last slot.
  - Case SLOT_BITS == SAMPLE_BITS: that bit is the previous frame's last-channel LSB.
- i2s_lrck:
  - Stereo: equals slot[0].
  - TDM: 1 when count == 0, else 0.
  - Not delayed by mode.
- All outputs are registered and updated in the same clk cycle as the BCK fall. They are stable through the following rising edge.

## Timing
- Reset (reset_n low at clk edge) forces:
  - divider 0, count = CHANNELS*SLOT_BITS-1, all outputs 0;
  - delay flop 0, shift and replay registers 0, holding buffer empty.
- sample_ready is 1 from the first clk after reset release.
- Reset mid-frame aborts immediately. Outputs are 0 in the first cycle with reset_n low.
- After release:
  - first rise at clk CLK_DIV;
  - first fall (frame start, count 0) at clk 2*CLK_DIV.
- Frame period = 2*CLK_DIV*CHANNELS*SLOT_BITS clk. Every BCK half-period is exactly CLK_DIV clk.
- Accept → sample_ready low on the next clk. It returns high on the clk after the frame-start transfer.
- Latency: a frame accepted before a frame start reaches i2s_data at that frame start (LJ) or one BCK later (I2S).
- sample_in is captured only on accept. It may change freely at other times.

## Test plan
- Reset: hold reset_n low 10 clk while sample_valid=1 → all outputs 0, no accept. After release, sample_ready=1 and the first BCK fall is at clk 2*CLK_DIV.
- Stereo I2S, CHANNELS=2, SAMPLE_BITS=16, SLOT_BITS=16, CLK_DIV=2, frame L=16'hA5C3, R=16'h0F01 → per frame:
  - BCK period 4 clk, frame 128 clk;
  - lrck low for 16 bits;
  - data: previous R LSB, then A5C3 MSB-first; then R=0F01 delayed one bit.
- Left-justified, SLOT_BITS=24, SAMPLE_BITS=16 → MSB coincides with the lrck edge, bits 16..23 of each slot are 0, frame is 48 BCKs.
- TDM, CHANNELS=4 → lrck high exactly one BCK period (2*CLK_DIV clk) per frame, slots in order ch0..ch3.
- Underrun: stop sample_valid after one frame → the next frame repeats identical data, with underrun and frame_start both pulsing 1 clk. Valid asserted on the frame-start clk with the buffer empty → underrun, and that data plays the following frame.
- Backpressure: hold sample_valid=1 continuously → exactly one accept per frame, and sample_ready is low from accept to the next frame start.
